rr_arbiter: RTL

Round-robin arbiter that shares one downstream resource among up to eight requesters. It uses a rotating-priority encoder to pick the next requester, then holds a registered one-hot grant until the owner releases it, drops its request, or exceeds a hold limit. It sits between the `ui_in` request pins and the shared datapath, and its grant vector drives `uo_out` at the top level.

---
 rtl/rr_arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 32 +++
 rtl/rr_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and default sizing for the round-robin arbiter.
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int unsigned RR_NUM_REQ  = 8;
  localparam int unsigned RR_HOLD_MAX = 16;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request at or after i_ptr, wrapping circularly.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = RR_NUM_REQ,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic                 w_found;

  // Doubling the vector turns the circular search into a linear one upward from i_ptr.
  assign w_dbl = {i_req, i_req};
  assign o_any = |i_req;

  always_comb begin
    o_idx   = '0;
    w_found = 1'b0;
    for (int unsigned j = 0; j < 2 * NUM_REQ; j++) begin
      if (!w_found && (j >= 32'(i_ptr)) && w_dbl[j]) begin
        o_idx   = IDX_W'(j % NUM_REQ);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, release, owner-drop and hold-limit timeout.
module rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = RR_NUM_REQ,
  parameter int unsigned HOLD_MAX = RR_HOLD_MAX,
  parameter int unsigned IDX_W    = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_release,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_gnt_valid,
  output logic [IDX_W-1:0]   o_gnt_idx,
  output logic               o_timeout
);

  localparam int unsigned HC_W = $clog2(HOLD_MAX + 1);

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic               r_gnt_valid, w_gnt_valid_nxt;
  logic [IDX_W-1:0]   r_gnt_idx, w_gnt_idx_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
  logic [HC_W-1:0]    r_hold_cnt, w_hold_cnt_nxt;

  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic               w_owner_req;
  logic               w_expired;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  assign w_owner_req = i_req[r_gnt_idx];
  assign w_expired   = (r_hold_cnt == HC_W'(HOLD_MAX));

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_gnt_valid_nxt = r_gnt_valid;
    w_gnt_idx_nxt   = r_gnt_idx;
    w_timeout_nxt   = 1'b0;
    w_ptr_nxt       = r_ptr;
    w_hold_cnt_nxt  = r_hold_cnt;
    case (r_state)
      IDLE: begin
        w_gnt_nxt       = '0;
        w_gnt_valid_nxt = 1'b0;
        if (w_pick_any) begin
          w_gnt_nxt       = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
          w_gnt_idx_nxt   = w_pick_idx;
          w_gnt_valid_nxt = 1'b1;
          w_hold_cnt_nxt  = HC_W'(1);
          w_state_nxt     = GRANT;
        end
      end
      GRANT: begin
        if (i_release || !w_owner_req || w_expired) begin
          w_gnt_nxt       = '0;
          w_gnt_valid_nxt = 1'b0;
          // Release or owner drop wins over a coincident expiry: pulse only on expiry alone.
          w_timeout_nxt   = !i_release && w_owner_req;
          w_ptr_nxt       = (r_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;
          w_hold_cnt_nxt  = '0;
          w_state_nxt     = IDLE;
        end else begin
          w_hold_cnt_nxt  = r_hold_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_idx   <= '0;
      r_timeout   <= 1'b0;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
      r_timeout   <= w_timeout_nxt;
      r_ptr       <= w_ptr_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_valid = r_gnt_valid;
  assign o_gnt_idx   = r_gnt_idx;
  assign o_timeout   = r_timeout;

endmodule
